// File: rtl/inertial_delay_pkg.sv
// Shared types and helpers for the inertial delay bank: channel state encoding
// and the effective-delay rule applied when a transition is detected.
package inertial_delay_pkg;

  localparam int CNT_W_DEF = 4;
  // Widest delay the helper handles; callers cast to their own counter width.
  localparam int DLY_MAX_W = 16;

  typedef logic [DLY_MAX_W-1:0] dly_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } chan_state_e;

  // A programmed delay of zero behaves exactly like a delay of one edge.
  function automatic dly_t eff_delay(input logic tgt, input dly_t rise, input dly_t fall);
    dly_t d;
    d = tgt ? rise : fall;
    if (d == '0) d = dly_t'(1);
    return d;
  endfunction

endpackage

// File: rtl/inertial_delay_chan.sv
// One inertial delay channel: follows the (optionally inverted) input after the
// rise/fall delay captured at detection, swallowing pulses shorter than that.
module inertial_delay_chan
  import inertial_delay_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter bit INVERT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [CNT_W-1:0] rise_q,
  input  logic [CNT_W-1:0] fall_q,
  output logic             dout,
  output logic             busy
);

  chan_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             pend_reg;
  logic             dout_reg;
  logic             tgt;
  logic [CNT_W-1:0] dly;

  assign tgt = din ^ INVERT;
  assign dly = CNT_W'(eff_delay(tgt, dly_t'(rise_q), dly_t'(fall_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pend_reg  <= INVERT;
      dout_reg  <= INVERT;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (tgt != dout_reg) begin
            if (dly == CNT_W'(1)) begin
              dout_reg <= tgt;
            end else begin
              cnt_reg   <= dly - CNT_W'(1);
              pend_reg  <= tgt;
              state_reg <= ST_PEND;
            end
          end
        end
        ST_PEND: begin
          // Input reverted before the delay elapsed: drop the pulse entirely.
          if (tgt != pend_reg) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else if (cnt_reg == CNT_W'(1)) begin
            dout_reg  <= pend_reg;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign dout = dout_reg;
  assign busy = (state_reg == ST_PEND);

endmodule

// File: rtl/inertial_delay_bank.sv
// Bank of WIDTH independent inertial delay channels sharing programmable
// rise/fall delay registers.
module inertial_delay_bank
  import inertial_delay_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = CNT_W_DEF,
  parameter bit INVERT   = 1'b1,
  parameter int RISE_DEF = 2,
  parameter int FALL_DEF = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_rise,
  input  logic [CNT_W-1:0] cfg_fall,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] busy,
  output logic             any_busy,
  output logic [CNT_W-1:0] rise_q,
  output logic [CNT_W-1:0] fall_q
);

  logic [CNT_W-1:0] rise_reg;
  logic [CNT_W-1:0] fall_reg;

  // Channels see the pre-write values on a cfg_we edge, so a detection on
  // that same edge captures the old delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_reg <= CNT_W'(RISE_DEF);
      fall_reg <= CNT_W'(FALL_DEF);
    end else if (cfg_we) begin
      rise_reg <= cfg_rise;
      fall_reg <= cfg_fall;
    end
  end

  assign rise_q = rise_reg;
  assign fall_q = fall_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      inertial_delay_chan #(
        .CNT_W  (CNT_W),
        .INVERT (INVERT)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din[gi]),
        .rise_q (rise_reg),
        .fall_q (fall_reg),
        .dout   (dout[gi]),
        .busy   (busy[gi])
      );
    end
  endgenerate

  assign any_busy = |busy;

endmodule

// File: doc/inertial_delay_bank.md
Name: inertial_delay_bank

Overview:
- Clocked, parametrised successor to the single-bit inverting delay net.
- Drives WIDTH channels. Each channel's output follows its (optionally inverted) input after a programmable number of clock edges.
- Rise and fall delays are set independently.
- Inertial semantics: an input pulse shorter than the applicable delay is swallowed.
- Used as a synthesizable timing/glitch-filter stage and as a stimulus generator for timing-behaviour tests.

Parameters:
- WIDTH, 32, number of channels.
- CNT_W, 4, delay counter width; delays range 0..2^CNT_W-1.
- INVERT, 1, 1 = dout follows ~din (NOT-gate behaviour), 0 = buffer.
- RISE_DEF, 2, reset value of the rise-delay register.
- FALL_DEF, 1, reset value of the fall-delay register.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  loads cfg_rise/cfg_fall into delay registers at this edge.
- cfg_rise  in  CNT_W  delay (edges) for dout 0->1 transitions.
- cfg_fall  in  CNT_W  delay (edges) for dout 1->0 transitions.
- din  in  WIDTH  channel inputs, sampled each rising edge.
- dout  out  WIDTH  delayed, optionally inverted outputs (registered).
- busy  out  WIDTH  per-channel transition pending.
- any_busy  out  1  OR-reduction of busy (registered-equivalent, no extra latency).
- rise_q  out  CNT_W  current rise-delay register.
- fall_q  out  CNT_W  current fall-delay register.

Behaviour:
- Reset (async assert, sync-free deassert handled by clk):
  - dout = {WIDTH{INVERT[0]}}
  - busy = 0, any_busy = 0
  - rise_q = RISE_DEF, fall_q = FALL_DEF
  - all counters = 0
- Per channel:
  - tgt = din[i] ^ INVERT
  - d = rise_q if tgt==1, else fall_q
  - d = 0 is treated as 1.
- IDLE state (busy=0):
  - tgt == dout: stay IDLE.
  - tgt != dout, d == 1: dout <= tgt at this edge; stay IDLE.
  - tgt != dout, d >= 2: cnt <= d-1, pend <= tgt, go PENDING (busy=1).
- PENDING state:
  - tgt != pend (input reverted): cancel; go IDLE, cnt <= 0, dout unchanged. This is the pulse swallow.
  - else cnt == 1: dout <= pend, go IDLE.
  - else cnt <= cnt-1.
- Latency: dout takes the new value at the d-th rising edge, counting the first edge that samples the new din value. The input must be held for all d sampling edges.
- Delay capture:
  - d is captured at detection.
  - cfg_we during PENDING does not alter that channel's remaining count.
  - New values apply to transitions detected from the edge after the write.
  - rise_q/fall_q update at the cfg_we edge.
- Simultaneous events:
  - Channels are fully independent; any mix may detect, count or fire on the same edge.
  - A cfg_we coinciding with a detection edge uses the old (pre-write) registers.
- Reset mid-operation: all pending transitions are discarded immediately; outputs take reset values asynchronously.
- Counter never wraps: it is loaded only with d-1 <= 2^CNT_W-2, and decrements only while > 1.

Decomposition:
- Package inertial_delay_pkg:
  - channel state enum {ST_IDLE, ST_PEND}
  - default CNT_W constant
  - function eff_delay(tgt, rise, fall) implementing the d=0 -> 1 rule
- Sub-module inertial_delay_chan:
  - one channel: state, cnt, pend, dout bit, busy bit
  - instantiated WIDTH times via generate
  - top level holds the config registers and any_busy.

Test Plan:
- Reset defaults: rst_n=0, din=0 -> dout=32'hFFFF_FFFF, busy=0, rise_q=2, fall_q=1; release with din=0 -> dout stays all ones.
- Fall, d=1: din[0] 0->1 before edge k -> dout[0]=0 after edge k, busy[0] never asserts.
- Rise, d=2: din[3] 1->0 before edge k -> busy[3]=1 after edge k, dout[3]=1 and busy[3]=0 after edge k+1.
- Pulse swallow: cfg_rise=5; din[7] 1->0 for 3 edges then back to 1 -> busy[7] high for 3 cycles then clears; dout[7] stays 0 throughout.
- Config during pending: rise=4, din[9] falls at edge k, cfg_rise=1 written at edge k+1 -> dout[9]=1 after edge k+3 (old delay honoured); next rise on another channel uses d=1.
- Async reset mid-pending and broadside:
  - din=32'hFFFF_FFFF with fall=3, then rst_n pulsed low at k+1 -> dout returns to all ones immediately, busy=0.
  - Repeat without reset -> all 32 bits fall on the same edge k+2.
